cluster_apu_arbiter: RTL and testbench



---
 rtl/cluster_apu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cluster_apu_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_apu_arbiter.sv
// Shares one cluster APU/FPU between NB_CORES cores: round-robin request
// arbitration with a sticky lock while the FPU stalls, and an in-order tag
// FIFO that routes every FPU response back to the core that issued it.
module cluster_apu_arbiter #(
    parameter int unsigned NB_CORES         = 8,
    parameter int unsigned WAPUTYPE         = 3,
    parameter int unsigned APU_NARGS_CPU    = 2,
    parameter int unsigned APU_WOP_CPU      = 1,
    parameter int unsigned APU_NDSFLAGS_CPU = 3,
    parameter int unsigned APU_NUSFLAGS_CPU = 5,
    parameter int unsigned TAG_DEPTH        = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    // core side
    input  logic [NB_CORES-1:0]                      core_req_i,
    output logic [NB_CORES-1:0]                      core_gnt_o,
    input  logic [NB_CORES*WAPUTYPE-1:0]             core_type_i,
    input  logic [NB_CORES*APU_NARGS_CPU*32-1:0]     core_operands_i,
    input  logic [NB_CORES*APU_WOP_CPU-1:0]          core_op_i,
    input  logic [NB_CORES*APU_NDSFLAGS_CPU-1:0]     core_flags_i,
    input  logic [NB_CORES-1:0]                      core_ready_i,
    output logic [NB_CORES-1:0]                      core_valid_o,
    output logic [31:0]                              core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]              core_flags_o,
    // FPU side
    output logic                                     fpu_req_o,
    input  logic                                     fpu_gnt_i,
    output logic [WAPUTYPE-1:0]                      fpu_type_o,
    output logic [APU_NARGS_CPU*32-1:0]              fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]                   fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]              fpu_flags_o,
    output logic                                     fpu_ready_o,
    input  logic                                     fpu_valid_i,
    input  logic [31:0]                              fpu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]              fpu_flags_i,
    // status
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int unsigned IdW  = $clog2(NB_CORES);
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);
    localparam int unsigned OpsW = APU_NARGS_CPU * 32;

    logic [IdW-1:0]  r_rr;
    logic            r_lock;
    logic [IdW-1:0]  r_lock_id;
    logic [IdW-1:0]  r_fifo [TAG_DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_lock_hold;
    logic [IdW-1:0]  w_idx;
    logic [IdW-1:0]  w_rr_winner;
    logic            w_found;
    logic [IdW-1:0]  w_winner;
    logic            w_issue;
    logic            w_pop;
    logic [IdW-1:0]  w_head;

    assign w_full  = (r_count == CntW'(TAG_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];

    // A lock only holds while the locked core keeps requesting; a dropped
    // request falls back to normal round-robin search.
    assign w_lock_hold = r_lock & core_req_i[r_lock_id];

    // Round-robin search: first requester at or above r_rr, wrapping.
    always_comb begin
        w_idx       = '0;
        w_rr_winner = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            w_idx = IdW'((32'(r_rr) + i) % NB_CORES);
            if (!w_found && core_req_i[w_idx]) begin
                w_rr_winner = w_idx;
                w_found     = 1'b1;
            end
        end
    end

    assign w_winner  = w_lock_hold ? r_lock_id : w_rr_winner;
    // Full suppresses requests even if a pop happens this cycle.
    assign fpu_req_o = (|core_req_i) & ~w_full;
    assign w_issue   = fpu_req_o & fpu_gnt_i;
    assign w_pop     = ~w_empty & fpu_valid_i & core_ready_i[w_head];

    // Request payload mux and grant decode; payload zeroed when idle.
    always_comb begin
        fpu_type_o     = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        core_gnt_o     = '0;
        if (fpu_req_o) begin
            fpu_type_o     = core_type_i[w_winner*WAPUTYPE +: WAPUTYPE];
            fpu_operands_o = core_operands_i[w_winner*OpsW +: OpsW];
            fpu_op_o       = core_op_i[w_winner*APU_WOP_CPU +: APU_WOP_CPU];
            fpu_flags_o    = core_flags_i[w_winner*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];
        end
        if (w_issue) begin
            core_gnt_o[w_winner] = 1'b1;
        end
    end

    // Response routing to the FIFO head; with nothing outstanding the
    // response is swallowed.
    always_comb begin
        core_valid_o = '0;
        fpu_ready_o  = 1'b1;
        if (!w_empty) begin
            core_valid_o[w_head] = fpu_valid_i;
            fpu_ready_o          = core_ready_i[w_head];
        end
    end

    assign core_result_o = fpu_result_i;
    assign core_flags_o  = fpu_flags_i;
    assign busy_o        = ~w_empty;
    assign err_o         = r_err;

    // Round-robin pointer and winner lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_issue) begin
            r_rr   <= (w_winner == IdW'(NB_CORES - 1)) ? '0 : w_winner + 1'b1;
            r_lock <= 1'b0;
        end else if (fpu_req_o) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_winner;
        end else begin
            r_lock <= 1'b0;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_issue) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag FIFO storage; contents are qualified by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_fifo[r_wptr] <= w_winner;
        end
    end

    // Sticky error: response with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_empty && fpu_valid_i) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cluster_apu_arbiter.sv
// Bench for cluster_apu_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the arbiter.
module tb_cluster_apu_arbiter;

    localparam int N   = 8;
    localparam int WT  = 3;
    localparam int NA  = 2;
    localparam int WOP = 1;
    localparam int NDS = 3;
    localparam int NUS = 5;
    localparam int TD  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, gnt_o, ready, valid_o;
    logic [N*WT-1:0]  ctype;
    logic [N*NA*32-1:0] cops;
    logic [N*WOP-1:0] cop;
    logic [N*NDS-1:0] cflg;
    logic [31:0]      cres;
    logic [NUS-1:0]   cusf;
    logic             fpu_req, fpu_gnt, fpu_ready, fpu_valid;
    logic [WT-1:0]    ftype;
    logic [NA*32-1:0] fops;
    logic [WOP-1:0]   fop;
    logic [NDS-1:0]   fflg;
    logic [31:0]      fres;
    logic [NUS-1:0]   fusf;
    logic             busy, err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_rr;
    bit m_lock;
    int m_lock_id;
    int m_q[$];
    bit m_err;

    cluster_apu_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_req_i      (req),
        .core_gnt_o      (gnt_o),
        .core_type_i     (ctype),
        .core_operands_i (cops),
        .core_op_i       (cop),
        .core_flags_i    (cflg),
        .core_ready_i    (ready),
        .core_valid_o    (valid_o),
        .core_result_o   (cres),
        .core_flags_o    (cusf),
        .fpu_req_o       (fpu_req),
        .fpu_gnt_i       (fpu_gnt),
        .fpu_type_o      (ftype),
        .fpu_operands_o  (fops),
        .fpu_op_o        (fop),
        .fpu_flags_o     (fflg),
        .fpu_ready_o     (fpu_ready),
        .fpu_valid_i     (fpu_valid),
        .fpu_result_i    (fres),
        .fpu_flags_i     (fusf),
        .busy_o          (busy),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int e_w();
        if (m_lock && req[m_lock_id]) return m_lock_id;
        for (int i = 0; i < N; i++) begin
            if (req[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return 0;
    endfunction

    function automatic bit e_req();
        return (req != '0) && (m_q.size() < TD);
    endfunction

    function automatic logic [N-1:0] e_gnt();
        return (e_req() && fpu_gnt) ? onehot(e_w()) : '0;
    endfunction

    function automatic logic [N-1:0] e_valid();
        return (m_q.size() > 0 && fpu_valid) ? onehot(m_q[0]) : '0;
    endfunction

    function automatic logic e_ready();
        return (m_q.size() == 0) ? 1'b1 : ready[m_q[0]];
    endfunction

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
        m_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int  w;
        bit  rq, issue, pop, empty;
        w     = e_w();
        rq    = e_req();
        issue = rq && fpu_gnt;
        empty = (m_q.size() == 0);
        pop   = !empty && fpu_valid && ready[m_q[0]];
        if (empty && fpu_valid) m_err = 1;
        if (pop) void'(m_q.pop_front());
        if (issue) begin
            m_q.push_back(w);
            m_rr   = (w + 1) % N;
            m_lock = 0;
        end else if (rq) begin
            m_lock    = 1;
            m_lock_id = w;
        end else begin
            m_lock = 0;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_core(input int i);
        ctype[i*WT +: WT] = WT'($urandom);
        for (int k = 0; k < NA; k++) cops[(i*NA + k)*32 +: 32] = $urandom;
        cop[i*WOP +: WOP]  = WOP'($urandom);
        cflg[i*NDS +: NDS] = NDS'($urandom);
    endtask

    task automatic idle_inputs();
        req = '0; ready = '0; fpu_gnt = 0; fpu_valid = 0;
        fres = '0; fusf = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        #2;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        req = '0; fpu_gnt = 0;
        while (m_q.size() > 0 && guard < 40) begin
            fpu_valid = 1; ready = '1;
            #1;
            total++;
            if (valid_o !== onehot(m_q[0])) begin
                bad++;
                $display("FAIL drain_valid got=%b exp=%b", valid_o, onehot(m_q[0]));
            end
            tick();
            guard++;
        end
        fpu_valid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #1;
        total += 5;
        if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        if (fpu_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", fpu_req); end
        if (gnt_o !== '0)     begin bad++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
        if (valid_o !== '0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_single();
        apply_reset();
        req = onehot(2); fpu_gnt = 1;
        #1;
        total += 2;
        if (gnt_o !== 8'b0000_0100) begin bad++; $display("FAIL single_gnt got=%b exp=00000100", gnt_o); end
        if (ftype !== ctype[2*WT +: WT]) begin bad++; $display("FAIL single_type got=%h exp=%h", ftype, ctype[2*WT +: WT]); end
        tick();
        req = '0; fpu_gnt = 0;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick();
        tick();
        fpu_valid = 1; fres = 32'h3F80_0000; ready = '1;
        #1;
        total += 2;
        if (valid_o !== 8'b0000_0100) begin bad++; $display("FAIL single_valid got=%b exp=00000100", valid_o); end
        if (cres !== 32'h3F80_0000) begin bad++; $display("FAIL single_result got=%h exp=3f800000", cres); end
        tick();
        fpu_valid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_fairness();
        int served[N];
        apply_reset();
        for (int i = 0; i < N; i++) served[i] = 0;
        req = '1; fpu_gnt = 1; ready = '1;
        for (int k = 0; k < 2*N; k++) begin
            fpu_valid = (m_q.size() > 0);
            #1;
            total += 2;
            if (gnt_o !== onehot(k % N)) begin
                bad++; $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, gnt_o, onehot(k % N));
            end
            if (valid_o !== e_valid()) begin
                bad++; $display("FAIL fair_valid k=%0d got=%b exp=%b", k, valid_o, e_valid());
            end
            if (k < N) begin
                for (int i = 0; i < N; i++) served[i] += int'(gnt_o[i]);
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (served[i] !== 1) begin bad++; $display("FAIL fair_count core=%0d got=%0d exp=1", i, served[i]); end
        end
        drain();
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 0; i < N; i++) rand_core(i);
        cops[1*NA*32 +: NA*32] = ~cops[5*NA*32 +: NA*32];
        for (int c = 0; c < 4; c++) begin
            req = (c >= 2) ? (onehot(5) | onehot(1)) : onehot(5);
            fpu_gnt = 0;
            #1;
            total += 2;
            if (fops !== cops[5*NA*32 +: NA*32]) begin
                bad++; $display("FAIL lock_payload c=%0d got=%h exp=%h", c, fops, cops[5*NA*32 +: NA*32]);
            end
            if (gnt_o !== '0) begin bad++; $display("FAIL lock_nogrant c=%0d got=%b exp=0", c, gnt_o); end
            tick();
        end
        fpu_gnt = 1;
        #1;
        total++;
        if (gnt_o !== onehot(5)) begin bad++; $display("FAIL lock_gnt5 got=%b exp=%b", gnt_o, onehot(5)); end
        tick();
        req = onehot(1);
        #1;
        total++;
        if (gnt_o !== onehot(1)) begin bad++; $display("FAIL lock_gnt1 got=%b exp=%b", gnt_o, onehot(1)); end
        tick();
        drain();
    endtask

    task automatic test_full();
        apply_reset();
        req = onehot(0); fpu_gnt = 1;
        for (int k = 0; k < TD; k++) begin
            #1;
            total++;
            if (fpu_req !== 1'b1) begin bad++; $display("FAIL full_fill k=%0d got=%b exp=1", k, fpu_req); end
            tick();
        end
        #1;
        total++;
        if (fpu_req !== 1'b0) begin bad++; $display("FAIL full_block got=%b exp=0", fpu_req); end
        tick();
        fpu_valid = 1; ready = '1;
        #1;
        total += 2;
        if (fpu_req !== 1'b0) begin bad++; $display("FAIL full_popcycle got=%b exp=0", fpu_req); end
        if (valid_o !== onehot(0)) begin bad++; $display("FAIL full_valid got=%b exp=%b", valid_o, onehot(0)); end
        tick();
        fpu_valid = 0;
        #1;
        total++;
        if (fpu_req !== 1'b1) begin bad++; $display("FAIL full_resume got=%b exp=1", fpu_req); end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        apply_reset();
        req = onehot(3); fpu_gnt = 1;
        #1; tick();
        req = onehot(6);
        #1; tick();
        req = '0; fpu_gnt = 0;
        fpu_valid = 1; fres = 32'hCAFE_0001; ready = ~onehot(3);
        for (int c = 0; c < 2; c++) begin
            #1;
            total += 3;
            if (fpu_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, fpu_ready); end
            if (valid_o !== onehot(3)) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, valid_o, onehot(3)); end
            if (cres !== 32'hCAFE_0001) begin bad++; $display("FAIL bp_result c=%0d got=%h exp=cafe0001", c, cres); end
            tick();
        end
        ready = '1; req = onehot(0); fpu_gnt = 1;
        #1;
        total += 3;
        if (valid_o !== onehot(3)) begin bad++; $display("FAIL bp_accept got=%b exp=%b", valid_o, onehot(3)); end
        if (fpu_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_hi got=%b exp=1", fpu_ready); end
        if (gnt_o !== onehot(0)) begin bad++; $display("FAIL bp_pushpop_gnt got=%b exp=%b", gnt_o, onehot(0)); end
        tick();
        req = '0; fpu_gnt = 0;
        #1;
        total += 2;
        if (valid_o !== onehot(6)) begin bad++; $display("FAIL bp_next6 got=%b exp=%b", valid_o, onehot(6)); end
        if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b exp=1", busy); end
        tick();
        #1;
        total++;
        if (valid_o !== onehot(0)) begin bad++; $display("FAIL bp_next0 got=%b exp=%b", valid_o, onehot(0)); end
        tick();
        fpu_valid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] eg;
        apply_reset();
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    rand_core(i);
                    if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
                end
            end
            req       = pend;
            fpu_gnt   = ($urandom_range(0, 2) != 0);
            ready     = N'($urandom);
            fpu_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            fres      = $urandom;
            fusf      = NUS'($urandom);
            #1;
            eg = e_gnt();
            total += 11;
            if (gnt_o !== eg) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt_o, eg); end
            if (fpu_req !== e_req()) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, fpu_req, e_req()); end
            if (ftype !== (e_req() ? ctype[e_w()*WT +: WT] : '0)) begin
                bad++; $display("FAIL rnd_type cyc=%0d got=%h", cyc, ftype);
            end
            if (fops !== (e_req() ? cops[e_w()*NA*32 +: NA*32] : '0)) begin
                bad++; $display("FAIL rnd_ops cyc=%0d got=%h", cyc, fops);
            end
            if (fop !== (e_req() ? cop[e_w()*WOP +: WOP] : '0)) begin
                bad++; $display("FAIL rnd_op cyc=%0d got=%h", cyc, fop);
            end
            if (fflg !== (e_req() ? cflg[e_w()*NDS +: NDS] : '0)) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got=%h", cyc, fflg);
            end
            if (valid_o !== e_valid()) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_o, e_valid()); end
            if (fpu_ready !== e_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, fpu_ready, e_ready()); end
            if (busy !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, busy); end
            if (err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, m_err); end
            if ({cres, cusf} !== {fres, fusf}) begin bad++; $display("FAIL rnd_resp cyc=%0d got=%h", cyc, cres); end
            pend = pend & ~eg;
            tick();
        end
        drain();
    endtask

    task automatic test_error_reset();
        apply_reset();
        fpu_valid = 1;
        #1;
        total += 2;
        if (fpu_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%b exp=1", fpu_ready); end
        if (valid_o !== '0) begin bad++; $display("FAIL err_novalid got=%b exp=0", valid_o); end
        tick();
        fpu_valid = 0;
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        tick();
        tick();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        req = onehot(1); fpu_gnt = 1;
        #1; tick();
        req = onehot(2);
        #1; tick();
        req = '0; fpu_gnt = 0;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL err_busy2 got=%b exp=1", busy); end
        rst = 1;
        #1;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        ctype = '0; cops = '0; cop = '0; cflg = '0;
        for (int i = 0; i < N; i++) rand_core(i);
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_full();
        test_backpressure();
        test_random();
        test_error_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
